noc_fifo_buffer: RTL and testbench



---
 rtl/noc_fifo_buffer.sv | 142 ++++++++++++++
 tb/tb_noc_fifo_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_fifo_buffer.sv
// noc_fifo_buffer: input-port flit FIFO for the 5-port NoC router.
// Sits between the link receiver and the route/arbitration stage. It supports
// simultaneous push/pop, a registered read port with a valid strobe, a
// synchronous flush, occupancy watermarks for upstream flow control, and
// one-cycle overflow/underflow error pulses.
//
// Occupancy is kept in its own register. The pointers therefore never need
// an extra wrap bit, and DEPTH does not have to be a power of two.

module noc_fifo_buffer #(
    parameter int WIDTH     = 16,  // flit width in bits
    parameter int DEPTH     = 5,   // storage entries, >= 2
    parameter int AF_MARGIN = 1,   // almost_full when count >= DEPTH-AF_MARGIN
    parameter int AE_MARGIN = 1    // almost_empty when count <= AE_MARGIN
) (
    input  logic                         clk,
    input  logic                         rst_n,
    // write side (link receiver)
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    // read side (route/arbitration stage)
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    // control
    input  logic                         flush,
    // status
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    // ------------------------------------------------------------------
    // Derived widths and decode thresholds
    // ------------------------------------------------------------------
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(AE_MARGIN);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;

    // Per-edge handshake decisions
    logic             rd_ok;
    logic             wr_ok;

    // Pointer advance. The wrap uses an explicit compare against the last
    // index rather than masking, so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Status decodes: purely combinational from the registered count, so
    // they add no latency.
    // ------------------------------------------------------------------
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_LEVEL);
    assign almost_full  = (count_q >= AF_LEVEL);
    assign almost_empty = (count_q <= AE_LEVEL);

    // ------------------------------------------------------------------
    // Acceptance. A read never depends on a same-cycle write, so an empty
    // FIFO never falls through. A write into a full FIFO is accepted only
    // when a read frees a slot on the same edge.
    // ------------------------------------------------------------------
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Next occupancy: +1 for a lone push, -1 for a lone pop, else unchanged.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that
        // leaves it unassigned would infer a latch.
        count_next = count_q;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_next = count_q + 1'b1;
            2'b01:   count_next = count_q - 1'b1;
            default: count_next = count_q;
        endcase
    end

    // Storage write port. Flush drops a same-cycle write.
    // NOTE: the storage array is deliberately not reset. Empty slots are
    // never read, and leaving out the reset lets the array map onto plain
    // RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (!flush && wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    // Control state: pointers, count, registered read port and error pulses.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            // Flush wins over any request. rd_data keeps its last value.
            wptr      <= '0;
            rptr      <= '0;
            count_q   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= next_ptr(wptr);
            end
            if (rd_ok) begin
                rd_data <= mem[rptr];
                rptr    <= next_ptr(rptr);
            end
            rd_valid  <= rd_ok;
            count_q   <= count_next;
            overflow  <= wr_en & ~wr_ok;
            underflow <= rd_en & ~rd_ok;
        end
    end

endmodule

// File: tb/tb_noc_fifo_buffer.sv
// tb_noc_fifo_buffer: directed self-checking bench for noc_fifo_buffer.
// A queue-based reference model decides acceptance on every edge. Flits a
// read should return go onto a scoreboard queue, and they are popped when
// the DUT raises rd_valid.

module tb_noc_fifo_buffer;

    localparam int WIDTH     = 16;
    localparam int DEPTH     = 5;
    localparam int AF_MARGIN = 1;
    localparam int AE_MARGIN = 1;
    localparam int CW        = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst_n;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             flush;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    int tests = 0;
    int fails = 0;

    // Reference model: current contents, plus the flits expected on rd_data.
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_rd;

    noc_fifo_buffer #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .AE_MARGIN (AE_MARGIN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .flush        (flush),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Occupancy must never exceed DEPTH.
    always @(negedge clk) begin
        if (rst_n) check("count_bound", 32'(count <= CW'(DEPTH)), 32'd1);
    end

    // Drive one cycle of requests, predict the result from the model, then
    // compare every output #1 after the edge.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic f);
        logic rok, wok, exp_ovf, exp_unf;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        flush   = f;
        rok     = r && !f && (model_q.size() > 0);
        wok     = w && !f && ((model_q.size() < DEPTH) || rok);
        exp_ovf = w && !f && !wok;
        exp_unf = r && !f && !rok;
        if (f) begin
            model_q.delete();
        end else begin
            if (rok) exp_q.push_back(model_q.pop_front());
            if (wok) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        flush = 1'b0;
        check("rd_valid", 32'(rd_valid), 32'(rok));
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                last_rd = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(last_rd));
            end
        end else begin
            check("rd_hold", 32'(rd_data), 32'(last_rd));
            exp_q.delete();
        end
        check("count",        32'(count),        32'(model_q.size()));
        check("empty",        32'(empty),        32'(model_q.size() == 0));
        check("full",         32'(full),         32'(model_q.size() == DEPTH));
        check("almost_full",  32'(almost_full),  32'(model_q.size() >= DEPTH - AF_MARGIN));
        check("almost_empty", 32'(almost_empty), 32'(model_q.size() <= AE_MARGIN));
        check("overflow",     32'(overflow),     32'(exp_ovf));
        check("underflow",    32'(underflow),    32'(exp_unf));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"},  32'(count),        32'd0);
        check({tag, "_empty"},  32'(empty),        32'd1);
        check({tag, "_full"},   32'(full),         32'd0);
        check({tag, "_af"},     32'(almost_full),  32'd0);
        check({tag, "_ae"},     32'(almost_empty), 32'd1);
        check({tag, "_rdv"},    32'(rd_valid),     32'd0);
        check({tag, "_rdd"},    32'(rd_data),      32'd0);
        check({tag, "_ovf"},    32'(overflow),     32'd0);
        check({tag, "_unf"},    32'(underflow),    32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        last_rd = '0;

        // Reset state
        #7;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1. Fill to full, one overflowing write, then drain in order
        for (int i = 1; i <= 5; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        check("t1_full",  32'(full),  32'd1);
        check("t1_count", 32'(count), 32'd5);
        step(1'b1, 16'hA006, 1'b0, 1'b0);
        check("t1_ovf", 32'(overflow), 32'd1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t1_ovf_pulse", 32'(overflow), 32'd0);
        for (int i = 1; i <= 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t1_empty", 32'(empty), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t1_unf", 32'(underflow), 32'd1);

        // 2. Full FIFO with simultaneous read and write
        for (int i = 1; i <= 5; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'hB000, 1'b1, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        check("t2_last", 32'(rd_data), 32'hB000);

        // 3. Empty FIFO with simultaneous read and write: no fall-through
        step(1'b1, 16'hC0DE, 1'b1, 1'b0);
        check("t3_unf",   32'(underflow), 32'd1);
        check("t3_count", 32'(count),     32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t3_data", 32'(rd_data), 32'hC0DE);

        // 4. Wrap-around: 12 alternating write/read pairs
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 16'(i), 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b0);
        end

        // 5. Watermarks: step occupancy 0 -> 5 -> 0 (decodes checked per step)
        for (int i = 0; i < 5; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);

        // 6a. Flush with requests pending in the same cycle
        for (int i = 0; i < 3; i++) step(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0);
        step(1'b1, 16'h6FFF, 1'b1, 1'b1);
        check("t6_flush_count", 32'(count), 32'd0);
        step(1'b1, 16'h6100, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);

        // 6b. Asynchronous reset with count = 4, checked before the next edge
        for (int i = 0; i < 4; i++) step(1'b1, 16'h7000 + 16'(i), 1'b0, 1'b0);
        check("t6_pre_reset", 32'(count), 32'd4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("mid_reset");
        model_q.delete();
        exp_q.delete();
        last_rd = '0;
        #3;
        rst_n = 1'b1;
        step(1'b1, 16'hD00D, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("t6_after_reset", 32'(rd_data), 32'hD00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
